// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state and memory-arbiter FSM state.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the datapath, the memory arbiter and the RAM model.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic        iREN, iwait;
    logic [31:0] iaddr, iload;
    logic        dREN, dWEN, dwait;
    logic [31:0] daddr, dstore, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t   ramstate;
    logic        busy, err;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Saturating grant-cycle counter; expired flags that TIMEOUT-1 cycles have elapsed.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store paths, with abort watchdog.
// Define FAIR_ARB_EN for alternating grants under contention; default is data-first priority.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        busy,
    output logic        err
);

    arbstate_t   state, next_state;
    logic [31:0] addr_q, store_q;
    logic        wr_q;
    logic        d_req, grant_d, expired;

    assign d_req = dREN | dWEN;

`ifdef FAIR_ARB_EN
    logic last_d;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_d <= 1'b1;
            end else if (iREN) begin
                last_d <= 1'b0;
            end
        end
    end

    assign grant_d = d_req & (~iREN | ~last_d);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completing ACCESS outranks both a dropped request and an abort.
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                if (ramstate == ACCESS) begin
                    iwait      = 1'b0;
                    next_state = IDLE;
                end else if (!iREN) begin
                    next_state = IDLE;
                end else if ((ramstate == ERROR) || expired) begin
                    err        = 1'b1;
                    next_state = IDLE;
                end
            end
            DGRANT: begin
                if (ramstate == ACCESS) begin
                    dwait      = 1'b0;
                    next_state = IDLE;
                end else if (!d_req) begin
                    next_state = IDLE;
                end else if ((ramstate == ERROR) || expired) begin
                    err        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                addr_q  <= daddr;
                store_q <= dstore;
                wr_q    <= dWEN;
            end else if (iREN) begin
                addr_q <= iaddr;
            end
        end
    end

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (state == IDLE),
        .count_en ((state != IDLE) && (ramstate != ACCESS)),
        .expired  (expired)
    );

    assign ramREN   = (state == IGRANT) | ((state == DGRANT) & ~wr_q);
    assign ramWEN   = (state == DGRANT) & wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iload    = ramload;
    assign dload    = ramload;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 8;

    logic CLK = 1'b0;
    logic nRST;
    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iwait    (bus.iwait),
        .iload    (bus.iload),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dwait    (bus.dwait),
        .dload    (bus.dload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .busy     (bus.busy),
        .err      (bus.err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: one outstanding grant, described by side/address/data/age.
    bit          model_live = 1'b0;
    bit          m_busy, m_side_d, m_wr;
    logic [31:0] m_addr, m_store;
    int          m_age;
`ifdef FAIR_ARB_EN
    bit          m_last_d;
`endif

    always @(posedge CLK) begin : model_update
        bit done, req, fail, pick_d;
        if (!nRST) begin
            m_busy = 1'b0; m_side_d = 1'b0; m_wr = 1'b0;
            m_addr = '0;   m_store = '0;    m_age = 0;
`ifdef FAIR_ARB_EN
            m_last_d = 1'b0;
`endif
            model_live = 1'b1;
        end else if (m_busy) begin
            done = (bus.ramstate == ACCESS);
            req  = m_side_d ? (bus.dREN | bus.dWEN) : bus.iREN;
            fail = (bus.ramstate == ERROR) || (m_age == TO - 1);
            if (done || !req || fail) m_busy = 1'b0;
            else if (m_age < TO - 1) m_age++;
        end else begin
`ifdef FAIR_ARB_EN
            pick_d = (bus.dREN | bus.dWEN) && (!bus.iREN || !m_last_d);
`else
            pick_d = bus.dREN | bus.dWEN;
`endif
            if (pick_d) begin
                m_busy = 1'b1; m_side_d = 1'b1; m_age = 0;
                m_addr = bus.daddr; m_store = bus.dstore; m_wr = bus.dWEN;
`ifdef FAIR_ARB_EN
                m_last_d = 1'b1;
`endif
            end else if (bus.iREN) begin
                m_busy = 1'b1; m_side_d = 1'b0; m_age = 0;
                m_addr = bus.iaddr;
`ifdef FAIR_ARB_EN
                m_last_d = 1'b0;
`endif
            end
        end
    end

    always @(negedge CLK) begin : compare
        bit done, req, exp_err;
        if (model_live) begin
            done    = m_busy && (bus.ramstate == ACCESS);
            req     = m_side_d ? (bus.dREN | bus.dWEN) : bus.iREN;
            exp_err = m_busy && !done && req &&
                      ((bus.ramstate == ERROR) || (m_age == TO - 1));
            check("busy",     32'(bus.busy),   32'(m_busy));
            check("ramREN",   32'(bus.ramREN), 32'(m_busy && (!m_side_d || !m_wr)));
            check("ramWEN",   32'(bus.ramWEN), 32'(m_busy && m_side_d && m_wr));
            check("ramaddr",  bus.ramaddr,     m_addr);
            check("ramstore", bus.ramstore,    m_store);
            check("iwait",    32'(bus.iwait),  32'(!(done && !m_side_d)));
            check("dwait",    32'(bus.dwait),  32'(!(done && m_side_d)));
            check("err",      32'(bus.err),    32'(exp_err));
            if (done && !m_side_d && bus.iREN) check("iload", bus.iload, bus.ramload);
            if (done && m_side_d && bus.dREN)  check("dload", bus.dload, bus.ramload);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [31:0] seq_exp [4];

    initial begin
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
`ifdef FAIR_ARB_EN
        seq_exp = '{32'h100, 32'h80, 32'h100, 32'h80};
`else
        seq_exp = '{32'h100, 32'h100, 32'h100, 32'h100};
`endif
        tick(); tick();
        settle();
        check("rst_busy",  32'(bus.busy),   32'd0);
        check("rst_iwait", 32'(bus.iwait),  32'd1);
        check("rst_dwait", 32'(bus.dwait),  32'd1);
        check("rst_ren",   32'(bus.ramREN), 32'd0);
        check("rst_wen",   32'(bus.ramWEN), 32'd0);
        check("rst_err",   32'(bus.err),    32'd0);
        check("rst_addr",  bus.ramaddr,     32'h0);

        // single fetch, ACCESS on first grant cycle
        nRST = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h40;
        settle();
        check("f_idle_iwait", 32'(bus.iwait), 32'd1);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        settle();
        check("f_iwait", 32'(bus.iwait),  32'd0);
        check("f_iload", bus.iload,       32'hDEADBEEF);
        check("f_addr",  bus.ramaddr,     32'h40);
        check("f_ren",   32'(bus.ramREN), 32'd1);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        settle();
        check("f_done_iwait", 32'(bus.iwait), 32'd1);
        check("f_done_busy",  32'(bus.busy),  32'd0);

        // contention: data first, then fetch after an IDLE cycle
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h100;
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0001;
        settle();
        check("c_addr",  bus.ramaddr,    32'h100);
        check("c_dwait", 32'(bus.dwait), 32'd0);
        check("c_iwait", 32'(bus.iwait), 32'd1);
        check("c_dload", bus.dload,      32'hCAFE0001);
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        settle();
        check("c_gap_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.ramstate = ACCESS;
        settle();
        check("c_i_addr",  bus.ramaddr,    32'h80);
        check("c_i_iwait", 32'(bus.iwait), 32'd0);
        tick();
        bus.dREN = 1'b1;
        settle();
        check("s_gap_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            check("arb_seq", bus.ramaddr, seq_exp[k]);
            tick();
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;

        // store with three BUSY cycles; inputs change mid-grant
        bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678; bus.ramstate = BUSY;
        for (int g = 1; g <= 4; g++) begin
            tick();
            if (g == 2) begin bus.dstore = 32'hFFFFFFFF; bus.daddr = 32'h999; end
            if (g == 4) bus.ramstate = ACCESS;
            settle();
            check("st_wen",   32'(bus.ramWEN), 32'd1);
            check("st_data",  bus.ramstore,    32'h12345678);
            check("st_addr",  bus.ramaddr,     32'h200);
            check("st_dwait", 32'(bus.dwait),  32'(g != 4));
        end
        tick();
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        settle();
        check("st_end_wen", 32'(bus.ramWEN), 32'd0);

        // read and write together is a write
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h210; bus.dstore = 32'hA5A5A5A5;
        bus.ramstate = ACCESS;
        tick();
        settle();
        check("rw_wen", 32'(bus.ramWEN), 32'd1);
        check("rw_ren", 32'(bus.ramREN), 32'd0);
        tick();
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

        // timeout on a stuck fetch, then re-grant
        bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.ramstate = BUSY;
        for (int g = 1; g <= TO; g++) begin
            tick();
            settle();
            check("to_err", 32'(bus.err), 32'(g == TO));
        end
        tick();
        settle();
        check("to_idle_busy", 32'(bus.busy), 32'd0);
        check("to_idle_err",  32'(bus.err),  32'd0);
        tick();
        bus.ramstate = ACCESS;
        settle();
        check("to_regrant",  bus.ramaddr,    32'h300);
        check("to_re_iwait", 32'(bus.iwait), 32'd0);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;

        // ACCESS in the timeout cycle completes without err
        bus.iREN = 1'b1; bus.iaddr = 32'h340; bus.ramstate = BUSY;
        for (int g = 1; g <= TO; g++) begin
            tick();
            if (g == TO) bus.ramstate = ACCESS;
            settle();
        end
        check("tw_err",   32'(bus.err),   32'd0);
        check("tw_iwait", 32'(bus.iwait), 32'd0);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;

        // RAM ERROR
        bus.dREN = 1'b1; bus.daddr = 32'h400;
        tick();
        bus.ramstate = ERROR;
        settle();
        check("er_err",   32'(bus.err),   32'd1);
        check("er_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        settle();
        check("er_next_err",  32'(bus.err),  32'd0);
        check("er_next_busy", 32'(bus.busy), 32'd0);

        // requester drops mid-grant
        bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = BUSY;
        tick();
        settle();
        check("dr_ren", 32'(bus.ramREN), 32'd1);
        tick();
        bus.iREN = 1'b0;
        settle();
        check("dr_err",     32'(bus.err),    32'd0);
        check("dr_ren_hld", 32'(bus.ramREN), 32'd1);
        tick();
        settle();
        check("dr_ren_off", 32'(bus.ramREN), 32'd0);
        check("dr_busy",    32'(bus.busy),   32'd0);
        bus.ramstate = FREE;

        // reset during a data grant
        bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h55; bus.ramstate = BUSY;
        tick();
        settle();
        check("rm_wen", 32'(bus.ramWEN), 32'd1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1; bus.dWEN = 1'b0; bus.ramstate = FREE;
        settle();
        check("rm_wen_off", 32'(bus.ramWEN), 32'd0);
        check("rm_busy",    32'(bus.busy),   32'd0);
        check("rm_err",     32'(bus.err),    32'd0);
        check("rm_addr",    bus.ramaddr,     32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
